// File: rtl/simd_mac_pkg.sv
// Shared definitions for the SIMD multiply-accumulate post stage:
// mode encodings, lane-count helper and the stage-1 control payload.
package simd_mac_pkg;

  localparam logic [1:0] MODE_16X16     = 2'b00;
  localparam logic [1:0] MODE_SUM_16X16 = 2'b01;
  localparam logic [1:0] MODE_SUM_8X8   = 2'b10;
  localparam logic [1:0] MODE_SUM_4X4   = 2'b11;

  // Control travelling with a beat from stage 1 into the accumulator
  typedef struct packed {
    logic [1:0] mode;
    logic       sgn;
    logic       clr;
  } s1_payload_t;

  // Number of independent accumulator lanes for a mode
  function automatic logic [2:0] lane_count(input logic [1:0] m);
    case (m)
      MODE_SUM_8X8: lane_count = 3'd2;
      MODE_SUM_4X4: lane_count = 3'd4;
      default:      lane_count = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_adder.sv
// One accumulator segment: LW-bit add with carry in/out and signed
// overflow detect. Segments are chained by the top to form wider lanes.
module simd_lane_adder #(
  parameter int LW = 12
) (
  input  logic [LW-1:0] acc_i,
  input  logic [LW-1:0] prod_i,
  input  logic          cin_i,
  output logic [LW-1:0] sum_o,
  output logic          cout_o,
  output logic          sovf_o
);

  logic [LW:0] full;

  assign full   = {1'b0, acc_i} + {1'b0, prod_i} + {{LW{1'b0}}, cin_i};
  assign sum_o  = full[LW-1:0];
  assign cout_o = full[LW];
  // Like-signed operands producing an opposite-signed result
  assign sovf_o = (acc_i[LW-1] == prod_i[LW-1]) && (sum_o[LW-1] != acc_i[LW-1]);

endmodule

// File: rtl/simd_mult_accumulator.sv
// Post-multiplier reduction and SIMD accumulation. Stage 1 forms the lane
// products and registers them lane-packed; stage 2 accumulates per lane with
// segmented carry chains and sticky overflow flags.
module simd_mult_accumulator
  import simd_mac_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      result_0,
  input  logic [31:0]      result_1,
  input  logic [3:0]       result_SIDM_carry,
  input  logic [1:0]       mode,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [3:0]       acc_ovf
);

  localparam int QW  = ACC_W / 4;
  localparam int LW2 = ACC_W / 2;
  localparam int LW4 = ACC_W / 4;

  logic             en;
  logic             vld_p1_q, vld_p2_q;
  logic             mode_vld_q;
  logic [1:0]       mode_q;
  s1_payload_t      ctl_p0, ctl_p1_q;
  logic [ACC_W-1:0] b_p0, b_p1_q;
  logic [31:0]      w_sum;
  logic [32:0]      w_sum33, p1_p0;
  logic [16:0]      h_sum [2];
  logic [8:0]       q_sum [4];
  logic [ACC_W-1:0] ext1, ext2, ext4;
  logic [ACC_W-1:0] acc_in_p2, acc_p2_d, acc_p2_q;
  logic [3:0]       ovf_p2_d, ovf_p2_q;
  logic [3:0]       start_mask, lane_mask, lflag, qflag, sovf;
  logic             co0, co1, co2, co3, ci1, ci2, ci3;

  assign en       = !(vld_p2_q && !out_ready);
  assign in_ready = en;

  // ---- stage 0: lane product formation ----
  assign w_sum   = result_0 + result_1;
  assign w_sum33 = {result_SIDM_carry[3], result_0} + {1'b0, result_1};

  for (genvar k = 0; k < 2; k++) begin : g_h
    assign h_sum[k] = {result_SIDM_carry[2*k+1], result_0[16*k +: 16]} + {1'b0, result_1[16*k +: 16]};
  end
  for (genvar k = 0; k < 4; k++) begin : g_b
    assign q_sum[k] = {result_SIDM_carry[k], result_0[8*k +: 8]} + {1'b0, result_1[8*k +: 8]};
  end

  // Beat control; a mode change or first beat after reset forces a load
  always_comb begin
    ctl_p0      = '0;
    ctl_p0.mode = mode;
    ctl_p0.sgn  = a_sign | b_sign;
    ctl_p0.clr  = acc_clear | !mode_vld_q | (mode != mode_q);
  end

  assign p1_p0 = (mode == MODE_16X16) ? {ctl_p0.sgn & w_sum[31], w_sum} : w_sum33;

  // Sign/zero extension of each lane product into its lane slot
  for (genvar j = 0; j < ACC_W; j++) begin : g_ext
    localparam int L2 = j / LW2;
    localparam int B2 = j % LW2;
    localparam int L4 = j / LW4;
    localparam int B4 = j % LW4;
    if (j < 33) begin : g_e1d
      assign ext1[j] = p1_p0[j];
    end else begin : g_e1f
      assign ext1[j] = ctl_p0.sgn & p1_p0[32];
    end
    if (B2 < 17) begin : g_e2d
      assign ext2[j] = h_sum[L2][B2];
    end else begin : g_e2f
      assign ext2[j] = ctl_p0.sgn & h_sum[L2][16];
    end
    if (B4 < 9) begin : g_e4d
      assign ext4[j] = q_sum[L4][B4];
    end else begin : g_e4f
      assign ext4[j] = ctl_p0.sgn & q_sum[L4][8];
    end
  end

  // Select the lane-packed product for the active mode
  always_comb begin
    b_p0 = ext1;
    case (lane_count(mode))
      3'd2:    b_p0 = ext2;
      3'd4:    b_p0 = ext4;
      default: b_p0 = ext1;
    endcase
  end

  // ---- stage 1 register ----
  // Stage-1 valid and stored-mode validity
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1_q   <= 1'b0;
      mode_vld_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= in_valid;
      if (in_valid) mode_vld_q <= 1'b1;
    end
  end

  // Stage-1 payload, captured only on an accepted beat
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      ctl_p1_q <= ctl_p0;
      b_p1_q   <= b_p0;
      mode_q   <= mode;
    end
  end

  // ---- stage 2: segmented accumulate ----
  assign acc_in_p2 = ctl_p1_q.clr ? '0 : acc_p2_q;

  // Lane boundaries, active-lane mask and per-lane flags by mode
  always_comb begin
    start_mask = 4'b0001;
    lane_mask  = 4'b0001;
    lflag      = {3'b000, qflag[3]};
    case (lane_count(ctl_p1_q.mode))
      3'd2: begin
        start_mask = 4'b0101;
        lane_mask  = 4'b0011;
        lflag      = {2'b00, qflag[3], qflag[1]};
      end
      3'd4: begin
        start_mask = 4'b1111;
        lane_mask  = 4'b1111;
        lflag      = qflag;
      end
      default: ;
    endcase
  end

  assign ci1 = !start_mask[1] && co0;
  assign ci2 = !start_mask[2] && co1;
  assign ci3 = !start_mask[3] && co2;

  simd_lane_adder #(.LW(QW)) u_seg0 (
    .acc_i(acc_in_p2[0*QW +: QW]), .prod_i(b_p1_q[0*QW +: QW]), .cin_i(1'b0),
    .sum_o(acc_p2_d[0*QW +: QW]), .cout_o(co0), .sovf_o(sovf[0]));
  simd_lane_adder #(.LW(QW)) u_seg1 (
    .acc_i(acc_in_p2[1*QW +: QW]), .prod_i(b_p1_q[1*QW +: QW]), .cin_i(ci1),
    .sum_o(acc_p2_d[1*QW +: QW]), .cout_o(co1), .sovf_o(sovf[1]));
  simd_lane_adder #(.LW(QW)) u_seg2 (
    .acc_i(acc_in_p2[2*QW +: QW]), .prod_i(b_p1_q[2*QW +: QW]), .cin_i(ci2),
    .sum_o(acc_p2_d[2*QW +: QW]), .cout_o(co2), .sovf_o(sovf[2]));
  simd_lane_adder #(.LW(QW)) u_seg3 (
    .acc_i(acc_in_p2[3*QW +: QW]), .prod_i(b_p1_q[3*QW +: QW]), .cin_i(ci3),
    .sum_o(acc_p2_d[3*QW +: QW]), .cout_o(co3), .sovf_o(sovf[3]));

  assign qflag    = ctl_p1_q.sgn ? sovf : {co3, co2, co1, co0};
  assign ovf_p2_d = ctl_p1_q.clr ? 4'b0000 : ((ovf_p2_q | lflag) & lane_mask);

  // ---- stage 2 register ----
  // Accumulator, sticky flags and output valid; bubbles leave acc untouched
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p2_q <= 1'b0;
      acc_p2_q <= '0;
      ovf_p2_q <= '0;
    end else if (en) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        acc_p2_q <= acc_p2_d;
        ovf_p2_q <= ovf_p2_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign acc_out   = acc_p2_q;
  assign acc_ovf   = ovf_p2_q;

endmodule
